// File: rtl/sa_attn_param.sv
`default_nettype none
// ============================================================================
//  Module      : sa_attn_param
//  Description : Parametrised single-head self-attention engine.
//                P = ReLU_opt((Q * K^T) / 3) * V,  Q = X*Wq, K = X*Wk, V = X*Wv
//                X (T_eff x DIM) and the three DIM x DIM weight matrices are
//                streamed in row-major, one element of each per beat. Q/K/V
//                and S are computed one element per cycle on a shared
//                DIM-wide dot-product unit; P elements are produced one per
//                output handshake.
//  Ports       : clk, rst        - clock / synchronous active-high reset
//                in_valid/ready  - load handshake (ready in IDLE/LOAD only)
//                T, mode         - sequence length, ReLU bypass (beat 0)
//                in_data         - X element
//                w_Q, w_K, w_V   - weight elements, parallel with in_data
//                out_valid/ready - result handshake
//                out_data        - P element, row-major, zero when not valid
//  Revision    : 1.0 - initial release
// ============================================================================
module sa_attn_param #(
    parameter  int DIM   = 8,
    parameter  int MAX_T = 8,
    parameter  int DW    = 8,
    localparam int QW    = 2*DW + $clog2(DIM),
    localparam int SW    = 2*QW + $clog2(DIM),
    localparam int OW    = SW + QW + $clog2(MAX_T),
    localparam int TW    = $clog2(MAX_T + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [TW-1:0]        T,
    input  logic                 mode,
    input  logic signed [DW-1:0] in_data,
    input  logic signed [DW-1:0] w_Q,
    input  logic signed [DW-1:0] w_K,
    input  logic signed [DW-1:0] w_V,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data
);

    localparam int c_DI = (DIM > 1)   ? $clog2(DIM)   : 1;  // DIM-range index width
    localparam int c_TI = (MAX_T > 1) ? $clog2(MAX_T) : 1;  // T-range index width
    localparam int c_MW = 2*QW;                             // shared product width
    localparam int c_PW = SW + QW;                          // S*V product width
    localparam logic signed [SW-1:0] c_THREE = SW'(3);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_QKV  = 3'd2,
        ST_S    = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    // Storage (no reset needed: every element read is written first in a job)
    logic signed [DW-1:0] r_x  [MAX_T][DIM];
    logic signed [DW-1:0] r_wq [DIM][DIM];
    logic signed [DW-1:0] r_wk [DIM][DIM];
    logic signed [DW-1:0] r_wv [DIM][DIM];
    logic signed [QW-1:0] r_q  [MAX_T][DIM];
    logic signed [QW-1:0] r_k  [MAX_T][DIM];
    logic signed [QW-1:0] r_v  [MAX_T][DIM];
    logic signed [SW-1:0] r_s  [MAX_T][MAX_T];

    // Control registers
    logic [c_DI-1:0]      r_lrow, r_lcol;     // load position
    logic [c_TI-1:0]      r_row;              // T-range row (QKV / S / OUT)
    logic [c_DI-1:0]      r_dcol;             // DIM-range column (QKV / OUT)
    logic [c_TI-1:0]      r_tcol;             // T-range column (S)
    logic [1:0]           r_mat;              // 0 = Q, 1 = K, 2 = V
    logic [c_TI-1:0]      r_tl;               // T_eff - 1
    logic                 r_mode;
    logic                 r_out_valid;
    logic                 r_out_last;         // final P element is in out_data
    logic signed [OW-1:0] r_out_data;

    // Combinational signals
    logic                 w_in_ready, w_beat;
    logic [c_TI-1:0]      w_tl, w_tl_use;
    logic                 w_load_last, w_qkv_last, w_s_last, w_out_last_elem;
    logic                 w_x_store;
    logic [c_TI-1:0]      w_x_row;
    logic signed [QW-1:0]   w_op_a [DIM];
    logic signed [QW-1:0]   w_op_b [DIM];
    logic signed [c_MW-1:0] w_prod [DIM];
    logic signed [SW-1:0]   w_dot, w_scaled, w_s_val;
    logic signed [c_PW-1:0] w_pprod [MAX_T];
    logic signed [OW-1:0]   w_p;

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign w_beat    = in_valid && w_in_ready;

    // Effective length from the T port: 0 or out-of-range means MAX_T.
    always_comb begin
        if (T == '0 || T > TW'(MAX_T)) begin
            w_tl = c_TI'(MAX_T - 1);
        end else begin
            w_tl = c_TI'(T - TW'(1));
        end
    end

    // Beat 0 arrives in IDLE before r_tl is latched, so use the live value.
    assign w_tl_use  = (r_state == ST_IDLE) ? w_tl : r_tl;
    assign w_x_store = int'(r_lrow) <= int'(w_tl_use);
    assign w_x_row   = c_TI'(r_lrow);

    assign w_load_last     = (r_lrow == c_DI'(DIM-1)) && (r_lcol == c_DI'(DIM-1));
    assign w_qkv_last      = (r_mat == 2'd2) && (r_row == r_tl) && (r_dcol == c_DI'(DIM-1));
    assign w_s_last        = (r_row == r_tl) && (r_tcol == r_tl);
    assign w_out_last_elem = (r_row == r_tl) && (r_dcol == c_DI'(DIM-1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_IDLE, ST_LOAD: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = w_load_last ? ST_QKV : ST_LOAD;
                end
            end
            ST_QKV: begin
                if (w_qkv_last) w_state_nxt = ST_S;
            end
            ST_S: begin
                if (w_s_last) w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (r_out_valid && out_ready && r_out_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------ shared dot product
    // QKV phase: X row times a weight column. S phase: Q row times K row.
    always_comb begin
        for (int k = 0; k < DIM; k++) begin
            w_op_a[k] = '0;
            w_op_b[k] = '0;
            if (r_state == ST_QKV) begin
                w_op_a[k] = QW'(r_x[r_row][k]);
                if (r_mat == 2'd0) begin
                    w_op_b[k] = QW'(r_wq[k][r_dcol]);
                end else if (r_mat == 2'd1) begin
                    w_op_b[k] = QW'(r_wk[k][r_dcol]);
                end else begin
                    w_op_b[k] = QW'(r_wv[k][r_dcol]);
                end
            end else if (r_state == ST_S) begin
                w_op_a[k] = r_q[r_row][k];
                w_op_b[k] = r_k[r_tcol][k];
            end
        end
    end

    always_comb begin
        w_dot = '0;
        for (int k = 0; k < DIM; k++) begin
            w_prod[k] = c_MW'(w_op_a[k]) * c_MW'(w_op_b[k]);
            w_dot     = w_dot + SW'(w_prod[k]);
        end
    end

    // Signed division truncates toward zero; ReLU keys off the sign bit.
    assign w_scaled = w_dot / c_THREE;
    assign w_s_val  = (!r_mode && w_scaled[SW-1]) ? '0 : w_scaled;

    // P element for (r_row, r_dcol); rows of V beyond T_eff are masked out
    // so stale data from an earlier, longer job never contributes.
    always_comb begin
        w_p = '0;
        for (int k = 0; k < MAX_T; k++) begin
            w_pprod[k] = c_PW'(r_s[r_row][k]) * c_PW'(r_v[k][r_dcol]);
            if (k <= int'(r_tl)) begin
                w_p = w_p + OW'(w_pprod[k]);
            end
        end
    end

    // ------------------------------------------------------- storage writes
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_wq[r_lrow][r_lcol] <= w_Q;
            r_wk[r_lrow][r_lcol] <= w_K;
            r_wv[r_lrow][r_lcol] <= w_V;
            if (w_x_store) begin
                r_x[w_x_row][r_lcol] <= in_data;
            end
        end
        if (r_state == ST_QKV) begin
            case (r_mat)
                2'd0:    r_q[r_row][r_dcol] <= w_dot[QW-1:0];
                2'd1:    r_k[r_row][r_dcol] <= w_dot[QW-1:0];
                default: r_v[r_row][r_dcol] <= w_dot[QW-1:0];
            endcase
        end
        if (r_state == ST_S) begin
            r_s[r_row][r_tcol] <= w_s_val;
        end
    end

    // ------------------------------------------------ counters and output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lrow      <= '0;
            r_lcol      <= '0;
            r_row       <= '0;
            r_dcol      <= '0;
            r_tcol      <= '0;
            r_mat       <= '0;
            r_tl        <= '0;
            r_mode      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_beat) begin
                        if (r_state == ST_IDLE) begin
                            r_tl   <= w_tl;
                            r_mode <= mode;
                        end
                        if (w_load_last) begin
                            r_lrow <= '0;
                            r_lcol <= '0;
                        end else if (r_lcol == c_DI'(DIM-1)) begin
                            r_lcol <= '0;
                            r_lrow <= r_lrow + c_DI'(1);
                        end else begin
                            r_lcol <= r_lcol + c_DI'(1);
                        end
                    end
                end
                ST_QKV: begin
                    if (r_dcol == c_DI'(DIM-1)) begin
                        r_dcol <= '0;
                        if (r_row == r_tl) begin
                            r_row <= '0;
                            r_mat <= (r_mat == 2'd2) ? 2'd0 : r_mat + 2'd1;
                        end else begin
                            r_row <= r_row + c_TI'(1);
                        end
                    end else begin
                        r_dcol <= r_dcol + c_DI'(1);
                    end
                end
                ST_S: begin
                    if (r_tcol == r_tl) begin
                        r_tcol <= '0;
                        r_row  <= (r_row == r_tl) ? '0 : r_row + c_TI'(1);
                    end else begin
                        r_tcol <= r_tcol + c_TI'(1);
                    end
                end
                ST_OUT: begin
                    // Counters point at the next element to present; the
                    // first OUT cycle (out_valid low) presents element 0.
                    if (!r_out_valid || out_ready) begin
                        if (r_out_valid && r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_p;
                            if (w_out_last_elem) begin
                                r_out_last <= 1'b1;
                                r_row      <= '0;
                                r_dcol     <= '0;
                            end else if (r_dcol == c_DI'(DIM-1)) begin
                                r_dcol <= '0;
                                r_row  <= r_row + c_TI'(1);
                            end else begin
                                r_dcol <= r_dcol + c_DI'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sa_attn_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sa_attn_param
//  Description : Self-checking bench for sa_attn_param. Expected P values come
//                from a plain matrix-arithmetic model of the attention rule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_attn_param;

    localparam int DIM   = 8;
    localparam int MAX_T = 8;
    localparam int DW    = 8;
    localparam int QW    = 2*DW + $clog2(DIM);
    localparam int SW    = 2*QW + $clog2(DIM);
    localparam int OW    = SW + QW + $clog2(MAX_T);
    localparam int TW    = $clog2(MAX_T + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [TW-1:0]        T = '0;
    logic                 mode = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic signed [DW-1:0] w_Q = '0;
    logic signed [DW-1:0] w_K = '0;
    logic signed [DW-1:0] w_V = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [OW-1:0] out_data;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     tx  [MAX_T][DIM];
    int     twq [DIM][DIM];
    int     twk [DIM][DIM];
    int     twv [DIM][DIM];
    longint exp_p [MAX_T*DIM];
    int     t_rand;

    sa_attn_param #(.DIM(DIM), .MAX_T(MAX_T), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .T         (T),
        .mode      (mode),
        .in_data   (in_data),
        .w_Q       (w_Q),
        .w_K       (w_K),
        .w_V       (w_V),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: straightforward matrix products on the stored operands.
    function automatic void model(input int teff, input bit md);
        longint q [MAX_T][DIM];
        longint k [MAX_T][DIM];
        longint v [MAX_T][DIM];
        longint s [MAX_T][MAX_T];
        longint acc;
        for (int r = 0; r < teff; r++) begin
            for (int c = 0; c < DIM; c++) begin
                q[r][c] = 0; k[r][c] = 0; v[r][c] = 0;
                for (int j = 0; j < DIM; j++) begin
                    q[r][c] += longint'(tx[r][j]) * twq[j][c];
                    k[r][c] += longint'(tx[r][j]) * twk[j][c];
                    v[r][c] += longint'(tx[r][j]) * twv[j][c];
                end
            end
        end
        for (int r = 0; r < teff; r++) begin
            for (int c = 0; c < teff; c++) begin
                acc = 0;
                for (int j = 0; j < DIM; j++) acc += q[r][j] * k[c][j];
                acc = acc / 3;
                if (!md && acc < 0) acc = 0;
                s[r][c] = acc;
            end
        end
        for (int r = 0; r < teff; r++) begin
            for (int c = 0; c < DIM; c++) begin
                acc = 0;
                for (int j = 0; j < teff; j++) acc += s[r][j] * v[j][c];
                exp_p[r*DIM + c] = acc;
            end
        end
    endfunction

    task automatic fill_const(input int xv, input int qv, input int kv, input int vv);
        for (int r = 0; r < MAX_T; r++)
            for (int c = 0; c < DIM; c++) tx[r][c] = xv;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                twq[r][c] = qv; twk[r][c] = kv; twv[r][c] = vv;
            end
    endtask

    task automatic fill_rand();
        for (int r = 0; r < MAX_T; r++)
            for (int c = 0; c < DIM; c++) tx[r][c] = int'($urandom_range(0, 255)) - 128;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                twq[r][c] = int'($urandom_range(0, 255)) - 128;
                twk[r][c] = int'($urandom_range(0, 255)) - 128;
                twv[r][c] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic pulse_reset(input string tag);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        check({tag, "_valid_in_rst"}, out_valid, 0);
        check({tag, "_data_in_rst"}, out_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check({tag, "_valid_after_rst"}, out_valid, 0);
        check({tag, "_ready_after_rst"}, in_ready, 1);
    endtask

    // stall_after / abort_load / abort_out < 0 disable the respective feature.
    task automatic run_job(input string tag, input int t_in, input bit md, input bit gaps,
                           input int stall_after, input int abort_load, input int abort_out);
        int  teff, nout, beat, guard, lat, zero_bad, n, stall_left;
        bit  acc, stalled;
        logic signed [OW-1:0] held;
        teff = (t_in == 0 || t_in > MAX_T) ? MAX_T : t_in;
        nout = teff * DIM;
        model(teff, md);
        out_ready = 1'b1;
        check({tag, "_ready_idle"}, in_ready, 1);
        beat = 0; guard = 0;
        while (beat < DIM*DIM) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (beat == 0) begin
                T = TW'(t_in); mode = md;
            end else begin
                T = TW'($urandom_range(0, 15)); mode = 1'($urandom_range(0, 1));
            end
            in_data = (beat / DIM < teff) ? DW'(tx[beat / DIM][beat % DIM]) : DW'($urandom_range(0, 255));
            w_Q = DW'(twq[beat / DIM][beat % DIM]);
            w_K = DW'(twk[beat / DIM][beat % DIM]);
            w_V = DW'(twv[beat / DIM][beat % DIM]);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) beat++;
            guard++;
            if (abort_load >= 0 && beat == abort_load) begin
                pulse_reset({tag, "_abort_load"});
                return;
            end
            if (guard > 2000) begin
                check({tag, "_load_timeout"}, beat, DIM*DIM);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        check({tag, "_ready_busy"}, in_ready, 0);

        lat = 0; zero_bad = 0;
        while (!out_valid && lat < 1000) begin
            if (out_data !== '0) zero_bad++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 3*teff*DIM + teff*teff + 1);
        check({tag, "_data_zero_pre"}, zero_bad, 0);
        if (!out_valid) return;

        n = 0; guard = 0; stall_left = 0; stalled = 1'b0; held = '0;
        while (n < nout && guard < 5000) begin
            if (abort_out >= 0 && n == abort_out) begin
                pulse_reset({tag, "_abort_out"});
                return;
            end
            if (!stalled && stall_after >= 0 && n == stall_after) begin
                stalled = 1'b1; stall_left = 5; held = out_data;
            end
            out_ready = (stall_left == 0);
            if (out_valid && out_ready) begin
                check($sformatf("%s_p%0d", tag, n), out_data, exp_p[n]);
                n++;
            end
            @(posedge clk); #1;
            guard++;
            if (stall_left > 0) begin
                stall_left--;
                check({tag, "_stall_hold"}, out_data, held);
                check({tag, "_stall_valid"}, out_valid, 1);
            end
        end
        out_ready = 1'b1;
        check({tag, "_out_count"}, n, nout);
        check({tag, "_valid_done"}, out_valid, 0);
        check({tag, "_data_done"}, out_data, 0);
        check({tag, "_ready_done"}, in_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        fill_const(1, 1, 1, 1);
        run_job("t1_ones", 1, 1'b0, 1'b0, -1, -1, -1);

        fill_const(1, 1, -1, 1);
        run_job("t2_relu", 2, 1'b0, 1'b0, -1, -1, -1);
        run_job("t2_norelu", 2, 1'b1, 1'b0, -1, -1, -1);

        fill_const(-128, -128, -128, -128);
        run_job("t8_min", 8, 1'b0, 1'b0, -1, -1, -1);

        fill_const(1, 1, 1, 1);
        run_job("t0_ones", 0, 1'b0, 1'b0, -1, -1, -1);
        run_job("t9_ones", 9, 1'b0, 1'b0, -1, -1, -1);

        fill_rand();
        run_job("bp_t5", 5, 1'b0, 1'b1, 3, -1, -1);

        for (int i = 0; i < 3; i++) begin
            fill_rand();
            t_rand = int'($urandom_range(1, MAX_T));
            run_job($sformatf("rnd%0d", i), t_rand, 1'($urandom_range(0, 1)), 1'b1, -1, -1, -1);
        end

        fill_rand();
        run_job("abort_ld", 8, 1'b0, 1'b1, -1, 20, -1);
        fill_rand();
        run_job("abort_out", 2, 1'b1, 1'b0, -1, -1, 3);
        fill_const(1, 1, 1, 1);
        run_job("fresh_t1", 1, 1'b0, 1'b0, -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
